// File: rtl/error_log_buffer_pkg.sv
// Shared types and constants for the error log buffer: flag bit positions, drain FSM states, record width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package err_log_pkg;

    localparam int FLAG_W_DEF = 7;

    localparam int FLG_CAMID            = 6;
    localparam int FLG_CAM_TIMEOUT      = 5;
    localparam int FLG_IMG_CAP_FAIL     = 4;
    localparam int FLG_CAM_NOT_DETECTED = 3;
    localparam int FLG_WRITE_FAIL       = 2;
    localparam int FLG_READ_FAIL        = 1;
    localparam int FLG_ERASE_FAIL       = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int rec_width(input int index_w, input int flag_w);
        return index_w + flag_w;
    endfunction

endpackage

// File: rtl/error_log_buffer_if.sv
// Capture strobe, flush control, drain stream and status of the error log buffer (drop_count with ERR_LOG_DROP_COUNT_EN).
// Latency: n/a (wiring only).
// Backpressure: out_ready throttles the drain stream; capture side has none.
interface error_log_buffer_if #(
    parameter int INDEX_W = 16,
    parameter int FLAG_W  = err_log_pkg::FLAG_W_DEF,
    parameter int DEPTH   = 8
) ();
    localparam int REC_W = err_log_pkg::rec_width(INDEX_W, FLAG_W);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [INDEX_W-1:0] in_index;
    logic [FLAG_W-1:0]  in_flags;
    logic               in_valid;
    logic               start_flush;
    logic [REC_W-1:0]   out_entry;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;
    logic               flush_busy;
    logic               flush_done;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               overflow;
`ifdef ERR_LOG_DROP_COUNT_EN
    logic [7:0]         drop_count;
`endif

    modport slave (
        input  in_index, in_flags, in_valid, start_flush, out_ready,
`ifdef ERR_LOG_DROP_COUNT_EN
        output drop_count,
`endif
        output out_entry, out_valid, out_last, flush_busy, flush_done, count, full, overflow
    );

    modport master (
        output in_index, in_flags, in_valid, start_flush, out_ready,
`ifdef ERR_LOG_DROP_COUNT_EN
        input  drop_count,
`endif
        input  out_entry, out_valid, out_last, flush_busy, flush_done, count, full, overflow
    );

endinterface

// File: rtl/error_log_buffer_ptr.sv
// Modulo-DEPTH pointer with increment/decrement and wrap; exposes current and next value.
// Latency: ptr updates on the edge after inc/dec; ptr_nxt is combinational lookahead.
// Backpressure: none.
module err_log_ptr #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             sysClk,
    input  logic             sysRst_n,
    input  logic             inc,
    input  logic             dec,
    output logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] ptr_nxt
);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    always_comb begin
        ptr_nxt = ptr;
        if (inc) begin
            ptr_nxt = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        end else if (dec) begin
            ptr_nxt = (ptr == '0) ? PTR_LAST : ptr - 1'b1;
        end
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            ptr <= '0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/error_log_buffer.sv
// Circular error-record log drained oldest- or newest-first on flush; ERR_LOG_DROP_COUNT_EN adds drop_count.
// Latency: capture reflected in count next cycle; first flushed record one cycle after start_flush.
// Backpressure: none on capture (losses set overflow); out_entry held while out_valid && !out_ready.
module error_log_buffer
    import err_log_pkg::*;
#(
    parameter int INDEX_W      = 16,
    parameter int FLAG_W       = FLAG_W_DEF,
    parameter int DEPTH        = 8,
    parameter bit OVERWRITE    = 1'b1,
    parameter bit NEWEST_FIRST = 1'b1
) (
    input logic               sysClk,
    input logic               sysRst_n,
    error_log_buffer_if.slave bus
);
    localparam int REC_W = rec_width(INDEX_W, FLAG_W);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [REC_W-1:0]   in_rec, src_rec, out_entry_q;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, src_idx;
    logic               out_valid_q, out_last_q, overflow_q;
    logic               full, accept, we, wr_inc, wr_dec, rd_inc, lost, load_out, bypass;

    assign in_rec = {bus.in_index, bus.in_flags};
    assign full   = (count_q == CNT_FULL);
    assign accept = out_valid_q && bus.out_ready;

    err_log_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
        .sysClk(sysClk), .sysRst_n(sysRst_n), .inc(wr_inc), .dec(wr_dec),
        .ptr(wr_ptr_q), .ptr_nxt(wr_ptr_d)
    );

    err_log_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
        .sysClk(sysClk), .sysRst_n(sysRst_n), .inc(rd_inc), .dec(1'b0),
        .ptr(rd_ptr_q), .ptr_nxt(rd_ptr_d)
    );

    // Next record to present is looked up from post-update pointers; a same-cycle
    // capture has not reached the RAM yet, so it is forwarded directly.
    assign src_idx = NEWEST_FIRST ? ((wr_ptr_d == '0) ? PTR_LAST : wr_ptr_d - 1'b1) : rd_ptr_d;
    assign bypass  = NEWEST_FIRST ? we : (we && !rd_inc && (wr_ptr_q == rd_ptr_q));
    assign src_rec = bypass ? in_rec : mem[src_idx];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        we       = 1'b0;
        wr_inc   = 1'b0;
        wr_dec   = 1'b0;
        rd_inc   = 1'b0;
        lost     = 1'b0;
        load_out = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (bus.in_valid) begin
                    if (!full) begin
                        we      = 1'b1;
                        wr_inc  = 1'b1;
                        count_d = count_q + 1'b1;
                    end else begin
                        lost = 1'b1;
                        if (OVERWRITE) begin
                            we     = 1'b1;
                            wr_inc = 1'b1;
                            rd_inc = 1'b1;
                        end
                    end
                end
                if (state_q == DONE) begin
                    state_d = IDLE;
                end else if (bus.start_flush) begin
                    if (count_d == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d  = DRAIN;
                        load_out = 1'b1;
                    end
                end
            end
            DRAIN: begin
                lost = bus.in_valid;
                if (accept) begin
                    count_d = count_q - 1'b1;
                    if (NEWEST_FIRST) wr_dec = 1'b1;
                    else              rd_inc = 1'b1;
                    if (count_q == CNT_ONE) state_d  = DONE;
                    else                    load_out = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sysClk) begin
        if (we) mem[wr_ptr_q] <= in_rec;
    end

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state_q     <= IDLE;
            count_q     <= '0;
            out_entry_q <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (load_out) begin
                out_entry_q <= src_rec;
                out_valid_q <= 1'b1;
                out_last_q  <= (count_d == CNT_ONE);
            end else if (accept) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (state_q == DONE) overflow_q <= 1'b0;
            else if (lost)       overflow_q <= 1'b1;
        end
    end

`ifdef ERR_LOG_DROP_COUNT_EN
    logic [7:0] drop_cnt_q;

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            drop_cnt_q <= '0;
        end else if (state_q == DONE) begin
            drop_cnt_q <= '0;
        end else if (lost && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign bus.drop_count = drop_cnt_q;
`endif

    assign bus.out_entry  = out_entry_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign bus.flush_busy = (state_q == DRAIN);
    assign bus.flush_done = (state_q == DONE);
    assign bus.count      = count_q;
    assign bus.full       = full;
    assign bus.overflow   = overflow_q;

endmodule

// File: doc/error_log_buffer.md
Name: error_log_buffer

Overview:
Parametrised error-record store; successor to the fixed 8-entry error table in the main-control FPGA. Captures one error record (image/flash index plus fault flags) per valid strobe into a circular buffer of DEPTH entries with a selectable full policy. On a flush request it drains the stored records over a valid/ready stream toward the telemetry/UART packer, oldest-first or newest-first, then empties itself. Reports occupancy, overflow and flush completion to the main control FSM.

Parameters:
INDEX_W, 16, width of error index field
FLAG_W, 7, width of fault-flag vector (camid, cam_timeout, img_cap_fail, cam_not_detected, write_fail, read_fail, erase_fail)
DEPTH, 8, number of entries; any value >= 2, not required to be a power of two
OVERWRITE, 1, 1 = when full, new record replaces oldest; 0 = when full, new record dropped
NEWEST_FIRST, 1, 1 = flush drains newest to oldest; 0 = oldest to newest

Ports:
sysClk  in  1  system clock, all logic on rising edge
sysRst_n  in  1  asynchronous active-low reset
in_index  in  INDEX_W  error index
in_flags  in  FLAG_W  fault flags, MSB = camid
in_valid  in  1  capture strobe; no backpressure
start_flush  in  1  single-cycle flush request
out_entry  out  INDEX_W+FLAG_W  record {index, flags}
out_valid  out  1  out_entry valid
out_ready  in  1  consumer accepts when out_valid && out_ready
out_last  out  1  high with final record of a flush
flush_busy  out  1  high while flushing
flush_done  out  1  one-cycle pulse at end of flush
count  out  $clog2(DEPTH+1)  stored entries
full  out  1  count == DEPTH
overflow  out  1  sticky: a record was lost or overwritten; cleared at flush_done

Behaviour:
- Reset (async assert, sync release): count=0, pointers=0, state IDLE, out_valid=0, out_last=0, flush_busy=0, flush_done=0, overflow=0. out_entry=0. Table RAM contents not reset.
- States: IDLE, DRAIN, DONE.
- IDLE capture: in_valid -> record written at wr_ptr next edge; wr_ptr wraps DEPTH-1 -> 0; count+1. Full & OVERWRITE=1: write at wr_ptr, rd_ptr advances, count stays DEPTH, overflow<=1. Full & OVERWRITE=0: record discarded, overflow<=1.
- IDLE, start_flush: count==0 -> DONE directly (no out_valid). Else -> DRAIN; flush_busy=1 from next cycle. start_flush with in_valid same cycle: the capture completes first and is included in the flush.
- DRAIN: out_valid registered; first record presented 1 cycle after start_flush. Source = oldest (rd_ptr) or newest (wr_ptr-1 with wrap) per NEWEST_FIRST. out_entry stable while out_valid && !out_ready. On accept: count-1, pointer steps (with wrap), next record presented next cycle (no bubble, one record/cycle at out_ready=1). out_last=1 when count==1. Accept of last record -> DONE.
- in_valid during DRAIN: not stored; overflow<=1.
- start_flush while DRAIN/DONE: ignored.
- DONE: flush_done=1 for one cycle, overflow<=0 (unless in_valid this cycle, which is stored normally), flush_busy=0, -> IDLE.
- Reset mid-DRAIN: buffer empties, no flush_done.

Optional Feature:
ERR_LOG_DROP_COUNT_EN defined: adds output drop_count (8 bits), incremented per lost/overwritten/during-flush record, saturates at 255, cleared with overflow at flush_done, reset 0. Undefined: port and counter absent; overflow flag only.

Decomposition:
- Package err_log_pkg: FLAG_W default, flag bit-position constants (FLG_CAMID .. FLG_ERASE_FAIL), state enum {IDLE, DRAIN, DONE}, record width function.
- One sub-module: err_log_ptr — modulo-DEPTH pointer with inc/dec and wrap; instanced for wr and rd.

Test Plan:
- DEPTH=8, 3 captures idx 0x0011/0x0022/0x0033, flush, out_ready=1, NEWEST_FIRST=1 -> 0x0033,0x0022,0x0011 on consecutive cycles, out_last with 0x0011, flush_done next cycle, count=0.
- OVERWRITE=1: 10 captures idx 1..10, flush, NEWEST_FIRST=0 -> records 3..10, overflow=1 until flush_done.
- OVERWRITE=0: 10 captures -> flush yields 1..8, overflow=1, drop_count=2 when ERR_LOG_DROP_COUNT_EN.
- Backpressure: out_ready toggled 1,0,0,1 -> out_entry held during stall, no record duplicated or skipped.
- Flush with count=0 -> flush_done one cycle later, out_valid never high; in_valid during DRAIN -> not stored, overflow=1.
- sysRst_n low mid-DRAIN after 2 of 5 accepts -> all outputs reset immediately, count=0, no flush_done.
